// File: rtl/qe_decoder.sv
`timescale 1ns/1ps
// qe_decoder: synchronised, glitch-filtered x4 quadrature decoder with index
// homing and a saturating step-to-step period timer.
module qe_decoder #(
  parameter int COUNT_WIDTH   = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   QE_A,
  input  logic                   QE_B,
  input  logic                   QE_I,
  input  logic                   invert_dir,
  input  logic                   clear_count,
  input  logic                   clear_error,
  input  logic                   home_arm,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   direction,
  output logic                   step_strobe,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] index_position,
  output logic [1:0]             home_state,
  output logic [COUNT_WIDTH-1:0] edge_period,
  output logic                   period_ovf
);

  typedef enum logic [1:0] {
    HOME_IDLE  = 2'd0,
    HOME_ARMED = 2'd1,
    HOME_HOMED = 2'd2
  } home_e;

  localparam int                     SW        = 3 * SYNC_STAGES;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [7:0]             FILT_LAST = 8'(FILTER_CYCLES - 1);

  logic [SW-1:0]          sync_q;
  logic [2:0]             synced_s;
  logic [2:0]             filt_q;
  logic [7:0]             filt_cnt_q [3];
  logic [1:0]             prev_ab_q;
  logic                   prev_i_q;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] index_q, index_d;
  logic [COUNT_WIDTH-1:0] timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   ovf_q, ovf_d;
  logic                   dir_q, dir_d;
  logic                   strobe_q, strobe_d;
  logic                   error_q, error_d;
  home_e                  home_q, home_d;

  logic [1:0]             ab_s;
  logic [1:0]             ab_chg_s;
  logic                   fwd_s;
  logic                   legal_s;
  logic                   illegal_s;
  logic                   i_rise_s;
  logic                   home_zero_s;
  logic                   step_s;
  logic                   up_s;
  logic                   timer_sat_s;

  // Bit order through the synchroniser and filter is {A, B, I}.
  assign synced_s = sync_q[SW-1 -: 3];

  // Synchroniser chain, all three pins shifted together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SW-4:0], QE_A, QE_B, QE_I};
    end
  end

  // Per-pin stability filter: flip only after FILTER_CYCLES mismatching cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        filt_cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (synced_s[i] != filt_q[i]) begin
          if (filt_cnt_q[i] == FILT_LAST) begin
            filt_q[i]     <= synced_s[i];
            filt_cnt_q[i] <= 8'd0;
          end else begin
            filt_cnt_q[i] <= filt_cnt_q[i] + 8'd1;
          end
        end else begin
          filt_cnt_q[i] <= 8'd0;
        end
      end
    end
  end

  // Transition decode on the filtered pins
  always_comb begin
    ab_s     = filt_q[2:1];
    ab_chg_s = ab_s ^ prev_ab_q;
    case ({prev_ab_q, ab_s})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd_s = 1'b1;
      default:                            fwd_s = 1'b0;
    endcase
    legal_s     = (ab_chg_s == 2'b01) || (ab_chg_s == 2'b10);
    illegal_s   = (ab_chg_s == 2'b11);
    i_rise_s    = filt_q[0] & ~prev_i_q;
    // Homing zero swallows a coincident step entirely.
    home_zero_s = enable & (home_q == HOME_ARMED) & i_rise_s;
    step_s      = enable & legal_s & ~home_zero_s;
    up_s        = fwd_s ^ invert_dir;
    timer_sat_s = (timer_q == CNT_MAX);
  end

  // Next-state for count, flags, homing FSM and period timer
  always_comb begin
    count_d  = count_q;
    index_d  = index_q;
    timer_d  = timer_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    dir_d    = dir_q;
    strobe_d = step_s;
    error_d  = error_q;
    home_d   = home_q;

    if (!enable) begin
      count_d = count_q;
    end else if (clear_count) begin
      count_d = '0;
    end else if (home_zero_s) begin
      count_d = '0;
    end else if (step_s) begin
      count_d = up_s ? (count_q + CNT_ONE) : (count_q - CNT_ONE);
    end else begin
      count_d = count_q;
    end

    if (step_s) begin
      dir_d = up_s;
    end else begin
      dir_d = dir_q;
    end

    if (enable && illegal_s) begin
      error_d = 1'b1;
    end else if (enable && clear_error) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end

    if (enable && i_rise_s) begin
      index_d = count_q;
    end else begin
      index_d = index_q;
    end

    case (home_q)
      HOME_IDLE:  home_d = (enable && home_arm) ? HOME_ARMED : HOME_IDLE;
      HOME_ARMED: home_d = home_zero_s ? HOME_HOMED : HOME_ARMED;
      HOME_HOMED: home_d = (enable && home_arm) ? HOME_ARMED : HOME_HOMED;
      default:    home_d = HOME_IDLE;
    endcase

    if (step_s) begin
      timer_d  = '0;
      period_d = timer_sat_s ? CNT_MAX : (timer_q + CNT_ONE);
      ovf_d    = timer_sat_s;
    end else if (enable && !timer_sat_s) begin
      timer_d = timer_q + CNT_ONE;
    end else begin
      timer_d = timer_q;
    end
  end

  // State registers; prev_ab/prev_i track every cycle so re-enable is clean
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_ab_q <= 2'b00;
      prev_i_q  <= 1'b0;
      count_q   <= '0;
      index_q   <= '0;
      timer_q   <= '0;
      period_q  <= '0;
      ovf_q     <= 1'b0;
      dir_q     <= 1'b0;
      strobe_q  <= 1'b0;
      error_q   <= 1'b0;
      home_q    <= HOME_IDLE;
    end else begin
      prev_ab_q <= ab_s;
      prev_i_q  <= filt_q[0];
      count_q   <= count_d;
      index_q   <= index_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      ovf_q     <= ovf_d;
      dir_q     <= dir_d;
      strobe_q  <= strobe_d;
      error_q   <= error_d;
      home_q    <= home_d;
    end
  end

  assign count          = count_q;
  assign direction      = dir_q;
  assign step_strobe    = strobe_q;
  assign error          = error_q;
  assign index_position = index_q;
  assign home_state     = home_q;
  assign edge_period    = period_q;
  assign period_ovf     = ovf_q;

endmodule

// File: tb/tb_qe_decoder.sv
`timescale 1ns/1ps
// tb_qe_decoder: randomized pin-level stimulus checked against a model that
// works in pin-change time (fixed 7-cycle pin-to-count latency).
module tb_qe_decoder;

  localparam int CW   = 8;
  localparam int PMAX = (1 << CW) - 1;
  localparam int LAT  = 7;

  logic          clk = 1'b0;
  logic          reset, enable, QE_A, QE_B, QE_I;
  logic          invert_dir, clear_count, clear_error, home_arm;
  logic [CW-1:0] count, index_position, edge_period;
  logic          direction, step_strobe, error, period_ovf;
  logic [1:0]    home_state;

  qe_decoder #(.COUNT_WIDTH(CW), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .QE_A(QE_A), .QE_B(QE_B), .QE_I(QE_I),
    .invert_dir(invert_dir), .clear_count(clear_count),
    .clear_error(clear_error), .home_arm(home_arm),
    .count(count), .direction(direction), .step_strobe(step_strobe),
    .error(error), .index_position(index_position), .home_state(home_state),
    .edge_period(edge_period), .period_ovf(period_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cnt = 0;

  // Model state
  logic [1:0]    gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0]    pab = 2'b00;
  logic [CW-1:0] exp_cnt = '0;
  logic [CW-1:0] exp_idx = '0;
  bit            exp_dir = 1'b0;
  bit            exp_err = 1'b0;
  int            exp_period = 0;
  bit            exp_ovf = 1'b0;
  int            exp_strobes = 0;
  int            last_step_edge = 0;

  always @(negedge clk) if (step_strobe === 1'b1) strobe_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int gidx(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (gray_seq[i] == v) return i;
    return 0;
  endfunction

  // One quarter-cycle pin move; if counted, update the model in pin time.
  task automatic move(input bit fwd, input bit counted, input int gap);
    int idx;
    int delta;
    int g;
    idx  = gidx(pab);
    idx  = fwd ? (idx + 1) % 4 : (idx + 3) % 4;
    pab  = gray_seq[idx];
    QE_A = pab[1];
    QE_B = pab[0];
    if (counted) begin
      delta   = (fwd ^ invert_dir) ? 1 : -1;
      exp_cnt = exp_cnt + delta[CW-1:0];
      exp_dir = (delta > 0);
      g       = cyc + LAT - last_step_edge;
      exp_ovf = (g > PMAX);
      exp_period = exp_ovf ? PMAX : g;
      last_step_edge = cyc + LAT;
      exp_strobes++;
    end
    repeat (gap) tick();
  endtask

  task automatic check_motion(input string tag);
    check_eq({tag, ".count"}, 32'(count), 32'(exp_cnt));
    check_eq({tag, ".dir"}, 32'(direction), 32'(exp_dir));
    check_eq({tag, ".strobes"}, 32'(strobe_cnt), 32'(exp_strobes));
    check_eq({tag, ".error"}, 32'(error), 32'(exp_err));
  endtask

  task automatic check_period(input string tag);
    check_eq({tag, ".period"}, 32'(edge_period), 32'(exp_period));
    check_eq({tag, ".ovf"}, 32'(period_ovf), 32'(exp_ovf));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".count"}, 32'(count), 32'd0);
    check_eq({tag, ".dir"}, 32'(direction), 32'd0);
    check_eq({tag, ".strobe"}, 32'(step_strobe), 32'd0);
    check_eq({tag, ".error"}, 32'(error), 32'd0);
    check_eq({tag, ".index"}, 32'(index_position), 32'd0);
    check_eq({tag, ".home"}, 32'(home_state), 32'd0);
    check_eq({tag, ".period"}, 32'(edge_period), 32'd0);
    check_eq({tag, ".ovf"}, 32'(period_ovf), 32'd0);
  endtask

  task automatic pulse_clear_count();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    int idx;
    bit fwd;
    int gap;
    reset = 1'b0; enable = 1'b0; QE_A = 1'b0; QE_B = 1'b0; QE_I = 1'b0;
    invert_dir = 1'b0; clear_count = 1'b0; clear_error = 1'b0; home_arm = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");

    reset = 1'b1;
    enable = 1'b1;
    last_step_edge = cyc;
    repeat (2) tick();

    // Eight forward quarter-cycles, 20 clk apart
    for (int i = 0; i < 8; i++) move(1'b1, 1'b1, 20);
    check_motion("fwd8");
    check_eq("fwd8.count_abs", 32'(count), 32'd8);
    check_period("fwd8");
    check_eq("fwd8.period_abs", 32'(edge_period), 32'd20);

    // Same stimulus with inverted direction
    invert_dir = 1'b1;
    pulse_clear_count();
    tick();
    check_eq("clear.count", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) move(1'b1, 1'b1, 20);
    check_motion("inv8");
    check_eq("inv8.count_abs", 32'(count), 32'hF8);
    invert_dir = 1'b0;

    // 3-cycle glitch on A must be filtered out
    QE_A = ~pab[1];
    repeat (3) tick();
    QE_A = pab[1];
    repeat (12) tick();
    check_motion("glitch");

    // Both pins change together: error, no count
    pab  = ~pab;
    QE_A = pab[1];
    QE_B = pab[0];
    exp_err = 1'b1;
    repeat (12) tick();
    check_motion("illegal");
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    exp_err = 1'b0;
    check_eq("clear_error", 32'(error), 32'd0);

    // Wrap at the signed boundary and below zero
    pulse_clear_count();
    for (int i = 0; i < 127; i++) move(1'b1, 1'b1, 9);
    check_eq("wrap.max", 32'(count), 32'h7F);
    move(1'b1, 1'b1, 9);
    check_motion("wrap.pos");
    check_eq("wrap.pos_abs", 32'(count), 32'h80);
    pulse_clear_count();
    move(1'b0, 1'b1, 9);
    check_motion("wrap.neg");
    check_eq("wrap.neg_abs", 32'(count), 32'hFF);

    // Randomized moves, gaps and direction inversion
    for (int i = 0; i < 40; i++) begin
      fwd = 1'($urandom_range(0, 1));
      invert_dir = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(8, 40));
      move(fwd, 1'b1, gap);
      check_motion($sformatf("rand%0d", i));
      check_period($sformatf("rand%0d", i));
    end
    invert_dir = 1'b0;

    // Period saturation boundary
    move(1'b1, 1'b1, 300);
    move(1'b1, 1'b1, 9);
    check_period("sat");
    check_eq("sat.ovf_abs", 32'(period_ovf), 32'd1);
    move(1'b1, 1'b1, 9);
    check_period("unsat");

    // Homing: count 100, arm, index with coincident step
    pulse_clear_count();
    for (int i = 0; i < 100; i++) move(1'b1, 1'b1, 9);
    check_eq("home.pre", 32'(count), 32'd100);
    home_arm = 1'b1;
    tick();
    home_arm = 1'b0;
    check_eq("home.armed", 32'(home_state), 32'd1);
    idx  = (gidx(pab) + 1) % 4;
    pab  = gray_seq[idx];
    QE_A = pab[1];
    QE_B = pab[0];
    QE_I = 1'b1;
    exp_idx = exp_cnt;
    exp_cnt = '0;
    repeat (12) tick();
    check_motion("homed");
    check_eq("homed.index", 32'(index_position), 32'(exp_idx));
    check_eq("homed.state", 32'(home_state), 32'd2);
    QE_I = 1'b0;
    repeat (10) tick();
    move(1'b1, 1'b1, 9);
    QE_I = 1'b1;
    exp_idx = exp_cnt;
    repeat (12) tick();
    check_motion("index2");
    check_eq("index2.index", 32'(index_position), 32'(exp_idx));
    check_eq("index2.state", 32'(home_state), 32'd2);
    QE_I = 1'b0;
    home_arm = 1'b1;
    tick();
    home_arm = 1'b0;
    check_eq("rearm.state", 32'(home_state), 32'd1);

    // Disabled window: pins move, nothing counts
    enable = 1'b0;
    for (int i = 0; i < 3; i++) move(1'($urandom_range(0, 1)), 1'b0, 17);
    enable = 1'b1;
    repeat (12) tick();
    check_motion("disabled");
    check_eq("disabled.home", 32'(home_state), 32'd1);

    // Reset mid-sequence, then release with pins at 11
    idx  = (gidx(pab) + 1) % 4;
    pab  = gray_seq[idx];
    QE_A = pab[1];
    QE_B = pab[0];
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_state("midreset");
    QE_A = 1'b1;
    QE_B = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (12) tick();
    check_eq("release11.error", 32'(error), 32'd1);
    check_eq("release11.count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
